// File: rtl/input_write_scheduler_if.sv
// Input-write port bundle: raw pad inputs and snooped CPU write in, memory input0/input1 writes out.
interface input_write_scheduler_if #(
  parameter int SIZE   = 16,
  parameter int ADDR_W = 6
);
  logic [3:0]        joy_raw;
  logic              btn_raw;
  logic              cpu_write_en;
  logic [ADDR_W-1:0] cpu_waddr;
  logic [SIZE-1:0]   input0_write_data;
  logic              input0_write_en;
  logic [SIZE-1:0]   input1_write_data;
  logic              input1_write_en;
  logic              btn_pending;

  modport master (
    output joy_raw, btn_raw, cpu_write_en, cpu_waddr,
    input  input0_write_data, input0_write_en, input1_write_data, input1_write_en, btn_pending
  );

  modport slave (
    input  joy_raw, btn_raw, cpu_write_en, cpu_waddr,
    output input0_write_data, input0_write_en, input1_write_data, input1_write_en, btn_pending
  );
endinterface

// File: rtl/input_write_scheduler.sv
// Debounces joystick/button pads and issues one-cycle memory writes on change; INPUT_WRITE_SCHEDULER_AUTOREPEAT_EN adds held-button repeat.
// Joystick strobe DEBOUNCE_CYCLES+3 cycles after a raw change; CPU writes to the same address win and the input write is retried.
module input_write_scheduler #(
  parameter int SIZE            = 16,
  parameter int ADDR_W          = 6,
  parameter int JOYSTICK_ADDR   = 0,
  parameter int BUTTON_ADDR     = 29,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input logic                  clk,
  input logic                  rst,
  input_write_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] JOY_A   = ADDR_W'(JOYSTICK_ADDR);
  localparam logic [ADDR_W-1:0] BTN_A   = ADDR_W'(BUTTON_ADDR);

  typedef enum logic [1:0] {IDLE, WRITE_JOY, WRITE_BTN} state_t;

  state_t           state;
  logic [4:0]       raw, sync1, sync2, stable;
  logic [CNT_W-1:0] db_cnt [5];
  logic [SIZE-1:0]  joy_code, last_joy, data0, data1;
  logic             en0, en1, btn_prev, btn_pending, btn_dirty;
  logic             joy_dirty, btn_rise, rpt_fire, btn_set, cpu_hit_joy, cpu_clr_btn;

  assign raw = {bus.btn_raw, bus.joy_raw};

  // Bit i of stable follows sync2 only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    joy_code = '0;
    if (stable[0])      joy_code = SIZE'(1);
    else if (stable[1]) joy_code = SIZE'(2);
    else if (stable[2]) joy_code = SIZE'(3);
    else if (stable[3]) joy_code = SIZE'(4);
  end

  assign joy_dirty   = (joy_code != last_joy);
  assign btn_rise    = stable[4] && !btn_prev;
  assign cpu_hit_joy = bus.cpu_write_en && (bus.cpu_waddr == JOY_A);
  assign cpu_clr_btn = bus.cpu_write_en && (bus.cpu_waddr == BTN_A);
  assign btn_set     = btn_rise || rpt_fire;

`ifdef INPUT_WRITE_SCHEDULER_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_cnt;

  // Phase-aligned to btn_prev so repeats land whole periods after the first press event.
  always_ff @(posedge clk) begin
    if (rst || !btn_prev)        rpt_cnt <= '0;
    else if (rpt_cnt == RPT_LAST) rpt_cnt <= '0;
    else                          rpt_cnt <= rpt_cnt + 1'b1;
  end

  assign rpt_fire = btn_prev && (rpt_cnt == RPT_LAST);
`else
  logic cfg_unused;
  assign cfg_unused = (REPEAT_CYCLES > 0);
  assign rpt_fire   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      en0         <= 1'b0;
      en1         <= 1'b0;
      data0       <= '0;
      data1       <= '0;
      last_joy    <= '0;
      btn_prev    <= 1'b0;
      btn_pending <= 1'b0;
      btn_dirty   <= 1'b0;
    end else begin
      btn_prev <= stable[4];

      // A new press beats a same-cycle CPU clear; a clear also cancels any outstanding write.
      if (btn_set) begin
        btn_pending <= 1'b1;
        btn_dirty   <= 1'b1;
      end else if (cpu_clr_btn) begin
        btn_pending <= 1'b0;
        btn_dirty   <= 1'b0;
      end else if (state == WRITE_BTN) begin
        btn_dirty <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (joy_dirty) begin
            state <= WRITE_JOY;
            en0   <= 1'b1;
            data0 <= joy_code;
          end else if (btn_dirty && btn_pending) begin
            state <= WRITE_BTN;
            en1   <= 1'b1;
            data1 <= SIZE'(1);
          end
        end
        WRITE_JOY: begin
          en0   <= 1'b0;
          state <= IDLE;
          if (!cpu_hit_joy) last_joy <= data0;
        end
        WRITE_BTN: begin
          en1   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          en0   <= 1'b0;
          en1   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.input0_write_data = data0;
  assign bus.input0_write_en   = en0;
  assign bus.input1_write_data = data1;
  assign bus.input1_write_en   = en1;
  assign bus.btn_pending       = btn_pending;
endmodule

// File: tb/tb_input_write_scheduler.sv
// Directed bench for input_write_scheduler at DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16.
module tb_input_write_scheduler;
  localparam int SIZE   = 16;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_write_scheduler_if #(.SIZE(SIZE), .ADDR_W(ADDR_W)) bus ();

  input_write_scheduler #(
    .SIZE(SIZE), .ADDR_W(ADDR_W), .JOYSTICK_ADDR(0), .BUTTON_ADDR(29),
    .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int w0_cnt = 0;
  int w1_cnt = 0;
  int overlap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample #1 later, tallying strobes seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.input0_write_en) w0_cnt++;
    if (bus.input1_write_en) w1_cnt++;
    if (bus.input0_write_en && bus.input1_write_en) overlap++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] addr);
    bus.cpu_write_en = 1'b1;
    bus.cpu_waddr    = addr;
    tick();
    bus.cpu_write_en = 1'b0;
    bus.cpu_waddr    = '0;
  endtask

  // Drive a joystick change and expect exactly one strobe 7 edges later.
  task automatic joy_window(input string tag, input logic [3:0] raw, input logic [15:0] code);
    bus.joy_raw = raw;
    ticks(6);
    check({tag, "_pre"}, 32'(bus.input0_write_en), 32'd0);
    tick();
    check({tag, "_en"}, 32'(bus.input0_write_en), 32'd1);
    check({tag, "_dat"}, 32'(bus.input0_write_data), 32'(code));
    tick();
    check({tag, "_post"}, 32'(bus.input0_write_en), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.joy_raw = 4'b0000;
    bus.btn_raw = 1'b0;
    bus.cpu_write_en = 1'b0;
    bus.cpu_waddr = '0;
    ticks(3);
    check("rst_en0", 32'(bus.input0_write_en), 32'd0);
    check("rst_en1", 32'(bus.input1_write_en), 32'd0);
    check("rst_dat0", 32'(bus.input0_write_data), 32'd0);
    check("rst_dat1", 32'(bus.input1_write_data), 32'd0);
    check("rst_pend", 32'(bus.btn_pending), 32'd0);
    rst = 1'b0;

    w0_cnt = 0; w1_cnt = 0;
    ticks(20);
    check("idle_w0", 32'(w0_cnt), 32'd0);
    check("idle_w1", 32'(w1_cnt), 32'd0);
    check("idle_pend", 32'(bus.btn_pending), 32'd0);

    // Joystick up, then release.
    w0_cnt = 0;
    joy_window("up", 4'b0001, 16'd1);
    ticks(8);
    joy_window("release", 4'b0000, 16'd0);
    ticks(8);
    check("joy_count", 32'(w0_cnt), 32'd2);

    // Short button pulse is filtered.
    w1_cnt = 0;
    bus.btn_raw = 1'b1;
    ticks(3);
    bus.btn_raw = 1'b0;
    ticks(15);
    check("short_w1", 32'(w1_cnt), 32'd0);
    check("short_pend", 32'(bus.btn_pending), 32'd0);

    // 10-cycle pulse gives one button write and a sticky flag.
    bus.btn_raw = 1'b1;
    ticks(7);
    check("btn_pre", 32'(bus.input1_write_en), 32'd0);
    check("btn_pend_rise", 32'(bus.btn_pending), 32'd1);
    tick();
    check("btn_en", 32'(bus.input1_write_en), 32'd1);
    check("btn_dat", 32'(bus.input1_write_data), 32'd1);
    ticks(2);
    bus.btn_raw = 1'b0;
    ticks(15);
    check("btn_count", 32'(w1_cnt), 32'd1);
    check("btn_pend_held", 32'(bus.btn_pending), 32'd1);
    cpu_write(6'd28);
    check("btn_other_addr", 32'(bus.btn_pending), 32'd1);
    cpu_write(6'd29);
    check("btn_cleared", 32'(bus.btn_pending), 32'd0);
    ticks(5);
    check("btn_no_rewrite", 32'(w1_cnt), 32'd1);

    // CPU collides with the joystick write: retried two cycles later.
    w0_cnt = 0;
    bus.joy_raw = 4'b0100;
    ticks(7);
    check("col_en", 32'(bus.input0_write_en), 32'd1);
    check("col_dat", 32'(bus.input0_write_data), 32'd3);
    cpu_write(6'd0);
    check("col_gap", 32'(bus.input0_write_en), 32'd0);
    tick();
    check("col_retry_en", 32'(bus.input0_write_en), 32'd1);
    check("col_retry_dat", 32'(bus.input0_write_data), 32'd3);
    ticks(10);
    check("col_count", 32'(w0_cnt), 32'd2);

    // Joystick and button debounce on the same edge.
    bus.joy_raw = 4'b1000;
    bus.btn_raw = 1'b1;
    ticks(7);
    check("sim_joy_en", 32'(bus.input0_write_en), 32'd1);
    check("sim_joy_dat", 32'(bus.input0_write_data), 32'd4);
    check("sim_btn_early", 32'(bus.input1_write_en), 32'd0);
    tick();
    check("sim_gap", 32'(bus.input0_write_en | bus.input1_write_en), 32'd0);
    tick();
    check("sim_btn_en", 32'(bus.input1_write_en), 32'd1);
    check("sim_joy_off", 32'(bus.input0_write_en), 32'd0);
    tick();
    bus.btn_raw = 1'b0;
    cpu_write(6'd29);
    check("sim_cleared", 32'(bus.btn_pending), 32'd0);
    ticks(15);

    // Direction priority.
    joy_window("prio_down", 4'b1110, 16'd2);
    ticks(8);
    joy_window("prio_up", 4'b1111, 16'd1);
    ticks(8);

    // Reset in the middle of a write, then the held input is re-debounced.
    bus.joy_raw = 4'b0100;
    ticks(7);
    check("rstw_en", 32'(bus.input0_write_en), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_drop", 32'(bus.input0_write_en), 32'd0);
    check("rstw_dat", 32'(bus.input0_write_data), 32'd0);
    check("rstw_pend", 32'(bus.btn_pending), 32'd0);
    joy_window("rstw_rejoy", 4'b0100, 16'd3);
    ticks(8);

    check("no_overlap", 32'(overlap), 32'd0);

`ifdef INPUT_WRITE_SCHEDULER_AUTOREPEAT_EN
    bus.btn_raw = 1'b1;
    ticks(7);
    check("rpt_first", 32'(bus.btn_pending), 32'd1);
    ticks(2);
    cpu_write(6'd29);
    check("rpt_clr1", 32'(bus.btn_pending), 32'd0);
    ticks(12);
    check("rpt_pre16", 32'(bus.btn_pending), 32'd0);
    tick();
    check("rpt_at16", 32'(bus.btn_pending), 32'd1);
    cpu_write(6'd29);
    check("rpt_clr2", 32'(bus.btn_pending), 32'd0);
    ticks(14);
    check("rpt_pre32", 32'(bus.btn_pending), 32'd0);
    tick();
    check("rpt_at32", 32'(bus.btn_pending), 32'd1);
    cpu_write(6'd29);
    bus.btn_raw = 1'b0;
    ticks(10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
